inst_mem_fetch: RTL
===================

// Module: inst_mem_fetch
// PURPOSE
//   Parametrised, synchronous instruction memory for the fetch stage. Replaces the
//   combinational fixed-image ROM. Fetch is a valid/ready request/response pair with
//   1-cycle latency, stall hold, flush and misalignment/range error flags.
//   A load port writes the image at run time (boot loader / testbench).
//   After reset, a clear sequencer zero-fills the array.
//   Sits between the pc_reg/if_id fetch logic and the instruction array.
// PARAMETERS
//   INST_W     64    instruction word width, bits; multiple of 8
//   ADDR_W     32    byte-address width
//   DEPTH      1024  words in array; power of 2, >= 2
//   DEPTH_LOG2 10    log2(DEPTH); must match DEPTH
//   CLEAR_EN   1     1: zero-fill array after reset; 0: skip straight to RUN
// PORTS
//   clk        in   1            clock, rising edge
//   rst        in   1            asynchronous, active-low reset
//   ce         in   1            chip enable; 0 blocks request acceptance
//   req_valid  in   1            fetch request valid
//   req_ready  out  1            fetch request accepted this cycle when both high
//   addr       in   ADDR_W       fetch byte address
//   flush      in   1            discard held response (branch/exception redirect)
//   rsp_valid  out  1            inst/rsp_err valid
//   rsp_ready  in   1            consumer takes response when both high
//   inst       out  INST_W       fetched instruction
//   rsp_err    out  2            [0] misaligned, [1] out of range
//   ld_valid   in   1            load-port write request
//   ld_ready   out  1            load-port accept
//   ld_addr    in   DEPTH_LOG2   load word index
//   ld_data    in   INST_W       load data
//   ld_be      in   INST_W/8     per-byte write enable
// BEHAVIOUR
//   - Word alignment: B = log2(INST_W/8). Word index = addr[DEPTH_LOG2+B-1:B].
//   - Reset (rst=0, async): state=CLEAR (CLEAR_EN=1) or RUN (CLEAR_EN=0).
//     clr_cnt=0; rsp_valid=0; inst=0; rsp_err=0; req_ready=0; ld_ready=0.
//     Array contents are not reset asynchronously.
//   - CLEAR: one word per cycle, mem[clr_cnt]<=0, clr_cnt++.
//     Leaves for RUN in the cycle after writing index DEPTH-1, so CLEAR lasts DEPTH cycles.
//     In CLEAR, req_ready=0 and ld_ready=0; inputs are ignored.
//   - RUN: ld_ready=1.
//     req_ready = ce & (~rsp_valid | rsp_ready | flush).
//   - Accept (req_valid & req_ready) at edge N: at edge N+1 rsp_valid=1 and
//     inst=mem[index] (synchronous read, registered).
//     rsp_err[0] = addr[B-1:0]!=0.
//     rsp_err[1] = addr[ADDR_W-1:DEPTH_LOG2+B]!=0. Tie this term to 0 when that
//     address field is empty.
//     If any error bit is set, inst=0 (NOP) and the array is not read.
//   - Stall: rsp_valid & ~rsp_ready & ~flush -> inst, rsp_err, rsp_valid hold stable.
//     No new request is accepted.
//   - Handshake: rsp_valid & rsp_ready with no new accept -> rsp_valid=0 next cycle.
//     Back-to-back accepts give one response per cycle.
//   - Flush: held response is dropped; rsp_valid=0 next cycle unless a request is
//     accepted in the same cycle, in which case the new response is presented.
//     Flush with no response pending has no effect.
//   - ce=0: no new accept. A held response stays until consumed or flushed.
//   - Load write (ld_valid & ld_ready): bytes with ld_be=1 of mem[ld_addr] are
//     updated at the edge.
//   - Same-cycle load and fetch to the same word: fetch returns OLD data
//     (read-before-write). The next fetch returns new data.
//   - Reset mid-CLEAR or mid-response: returns to reset values immediately.
//     CLEAR restarts from index 0.
//   - req_ready and ld_ready are combinational from state, ce, rsp_valid, rsp_ready
//     and flush. No combinational path from addr to any output.
// TESTING
//   1. Reset, CLEAR_EN=1, DEPTH=16 -> req_ready=0 for 16 cycles after rst rises.
//      Then every fetch of 0x0..0x78 returns inst=0.
//   2. Load idx 3 = 64'h2080800000008000, ld_be=8'hFF; fetch addr 0x18
//      -> next cycle rsp_valid=1, inst=64'h2080800000008000, rsp_err=0.
//   3. Fetch 0x1C -> rsp_err=2'b01, inst=0. Fetch 0x80 with DEPTH=16
//      -> rsp_err=2'b10, inst=0.
//   4. Response pending, rsp_ready=0 for 3 cycles -> inst stable, req_ready=0.
//      rsp_ready=1 -> consumed; back-to-back fetches 0x0,0x8,0x10 give 3 responses
//      on 3 consecutive cycles.
//   5. Pending response + flush + new fetch 0x20 same cycle -> old dropped;
//      next response is mem[4].
//      Load idx 2 with ld_be=8'h0F, data all-ones, plus same-cycle fetch 0x10
//      -> first read is old value; re-fetch gives low 4 bytes = 0xFF, high bytes kept.
//   6. Assert rst mid-CLEAR at clr_cnt=7 -> rsp_valid=0 at once.
//      After release, CLEAR takes a full 16 cycles.

Source files
------------

// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch: synchronous instruction memory for the fetch stage.
// Valid/ready fetch with 1-cycle latency, error flags, run-time load port and post-reset zero-fill.
`default_nettype none

module inst_mem_fetch #(
  parameter int INST_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int DEPTH_LOG2 = 10,
  parameter int CLEAR_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INST_W-1:0]     inst,
  output logic [1:0]            rsp_err,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [INST_W-1:0]     ld_data,
  input  logic [INST_W/8-1:0]   ld_be
);

  localparam int BYTES = INST_W / 8;
  localparam int B     = $clog2(BYTES);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [DEPTH_LOG2-1:0]   clr_cnt;
  logic [INST_W-1:0]       mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   idx;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    accept;

  assign idx    = addr[DEPTH_LOG2+B-1:B];
  assign accept = req_valid & req_ready;

  generate
    if (B > 0) begin : g_misalign
      assign misaligned = |addr[B-1:0];
    end else begin : g_no_misalign
      assign misaligned = 1'b0;
    end

    if (ADDR_W > DEPTH_LOG2 + B) begin : g_range
      assign out_of_range = |addr[ADDR_W-1:DEPTH_LOG2+B];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    ld_ready   = 1'b0;
    case (state)
      ST_CLEAR: begin
        // clr_cnt wraps to zero on the same edge that moves us to RUN
        if (&clr_cnt) next_state = ST_RUN;
      end
      ST_RUN: begin
        ld_ready  = 1'b1;
        req_ready = ce & (~rsp_valid | rsp_ready | flush);
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (ld_valid && ld_ready) begin
      for (int b = 0; b < BYTES; b++) begin
        if (ld_be[b]) mem[ld_addr][b*8 +: 8] <= ld_data[b*8 +: 8];
      end
    end
  end

  // Non-blocking read of mem gives read-before-write against a same-edge load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      inst      <= '0;
      rsp_err   <= 2'b00;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= {out_of_range, misaligned};
      if (out_of_range || misaligned) begin
        inst <= '0;
      end else begin
        inst <= mem[idx];
      end
    end else if (rsp_valid && (rsp_ready || flush)) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
